// File: rtl/mux4b4_reg.sv
// mux4b4_reg: registered 4-to-1 operand multiplexer for the datapath.
// Selects one of four WIDTH-bit operands by a 2-bit select. It provides a
// zero-latency combinational result and a clock-captured result with an
// accompanying valid flag that is high for the cycle after each load.
module mux4b4_reg #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       S,
    input  logic             EN,
    output logic [WIDTH-1:0] O_COMB,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID
);

    logic [WIDTH-1:0] sel_value;

    // Operand selection shared by the combinational output and the load
    // path. An unknown select propagates as all-X in simulation.
    always_comb begin
        sel_value = 'x;
        case (S)
            2'b00:   sel_value = A;
            2'b01:   sel_value = B;
            2'b10:   sel_value = C;
            2'b11:   sel_value = D;
            default: sel_value = 'x;
        endcase
    end

    assign O_COMB = sel_value;

    // Output register: loads the selected operand when enabled and holds
    // otherwise. Reset clears it immediately and discards any pending load.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            O <= RESET_VALUE;
        end else if (EN) begin
            O <= sel_value;
        end
    end

    // The valid flag marks the cycle that follows a load.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            O_VALID <= 1'b0;
        end else begin
            O_VALID <= EN;
        end
    end

endmodule

// File: tb/tb_mux4b4_reg.sv
// tb_mux4b4_reg: directed self-checking bench for mux4b4_reg, using a default
// 4-bit instance plus an 8-bit instance for the wide pass-through case.
module tb_mux4b4_reg;

    logic       clk;
    logic       reset_n;
    logic [3:0] a, b, c, d;
    logic [1:0] s;
    logic       en;
    logic [3:0] o_comb, o;
    logic       o_valid;

    logic [7:0] a8, b8, c8, d8;
    logic [7:0] o_comb8, o8;
    logic       o_valid8;

    int errors = 0;
    int checks = 0;

    mux4b4_reg dut (
        .CLK     (clk),
        .RESET_N (reset_n),
        .A       (a),
        .B       (b),
        .C       (c),
        .D       (d),
        .S       (s),
        .EN      (en),
        .O_COMB  (o_comb),
        .O       (o),
        .O_VALID (o_valid)
    );

    mux4b4_reg #(.WIDTH(8)) dut8 (
        .CLK     (clk),
        .RESET_N (reset_n),
        .A       (a8),
        .B       (b8),
        .C       (c8),
        .D       (d8),
        .S       (s),
        .EN      (en),
        .O_COMB  (o_comb8),
        .O       (o8),
        .O_VALID (o_valid8)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and tally it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one set of operand/select/enable values onto the 4-bit instance.
    task automatic applyStimulus(input logic [3:0] va, input logic [3:0] vb,
                                 input logic [3:0] vc, input logic [3:0] vd,
                                 input logic [1:0] vs, input logic ven);
        a  = va;
        b  = vb;
        c  = vc;
        d  = vd;
        s  = vs;
        en = ven;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Guard against a hung run.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0);
        a8 = 8'hA5; b8 = 8'h5A; c8 = 8'h3C; d8 = 8'hC3;

        // Reset state
        #12;
        checkOutput("reset_o", o, 4'h0);
        checkOutput("reset_valid", o_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // All selects back-to-back; O_COMB is immediate, O one edge later
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'h1, 4'h2, 4'h3, 4'h4, 2'(i), 1'b1);
            #1;
            checkOutput($sformatf("comb_s%0d", i), o_comb, 4'(i + 1));
            step();
            checkOutput($sformatf("reg_s%0d", i), o, 4'(i + 1));
            checkOutput($sformatf("valid_s%0d", i), o_valid, 1'b1);
        end

        // Hold: O keeps 4 while enable is low
        applyStimulus(4'h1, 4'h2, 4'h3, 4'hF, 2'd0, 1'b0);
        #1;
        checkOutput("hold_comb", o_comb, 4'h1);
        step();
        checkOutput("hold_o", o, 4'h4);
        checkOutput("hold_valid", o_valid, 1'b0);

        // Select change between edges affects only O_COMB until the edge
        applyStimulus(4'h1, 4'h2, 4'h3, 4'h4, 2'd0, 1'b1);
        step();
        checkOutput("timing_first", o, 4'h1);
        #2;
        s = 2'd2;
        #1;
        checkOutput("timing_comb", o_comb, 4'h3);
        checkOutput("timing_o_held", o, 4'h1);
        step();
        checkOutput("timing_o_new", o, 4'h3);

        // Boundary operand values
        applyStimulus(4'hF, 4'h2, 4'h3, 4'h0, 2'd0, 1'b1);
        step();
        checkOutput("bound_a_f", o, 4'hF);
        s = 2'd3;
        step();
        checkOutput("bound_d_0", o, 4'h0);

        // Wide instance passes 8-bit values unaltered
        s = 2'd0;
        #1;
        checkOutput("wide_comb", o_comb8, 8'hA5);
        step();
        checkOutput("wide_o_a", o8, 8'hA5);
        s = 2'd3;
        step();
        checkOutput("wide_o_d", o8, 8'hC3);

        // Asynchronous reset mid-cycle clears O and O_VALID immediately
        applyStimulus(4'h9, 4'h2, 4'h3, 4'h4, 2'd0, 1'b1);
        step();
        checkOutput("pre_reset_o", o, 4'h9);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_o", o, 4'h0);
        checkOutput("async_reset_valid", o_valid, 1'b0);
        checkOutput("async_reset_o8", o8, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // First edge after release loads normally
        applyStimulus(4'h1, 4'h2, 4'h3, 4'h4, 2'd1, 1'b1);
        step();
        checkOutput("post_reset_o", o, 4'h2);
        checkOutput("post_reset_valid", o_valid, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
